// File: rtl/utc_to_unix64_pkg.sv
// Shared calendar constants, FSM state type and calendar helpers.
// Used by the UTC -> Unix converter and by its inverse.
package utc_to_unix64_pkg;

    localparam int EPOCH_YEAR    = 1970;
    localparam int YEAR_MAX      = 9999;
    localparam int SECS_PER_DAY  = 86400;
    localparam int SECS_PER_HOUR = 3600;
    localparam int DAYS_W        = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_YEARS,
        ST_MONTHS,
        ST_CALC
    } state_t;

    // Days per month for a common year, January in the low 5 bits.
    localparam logic [59:0] DIM_TABLE = {
        5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31,
        5'd30, 5'd31, 5'd30, 5'd31, 5'd28, 5'd31
    };

    // Common-year length of a month; 0 for month numbers outside 1..12.
    function automatic logic [4:0] dim_base(input logic [3:0] month);
        logic [4:0] result;
        result = 5'd0;
        if (month >= 4'd1 && month <= 4'd12) begin
            result = DIM_TABLE[(int'(month) - 1) * 5 +: 5];
        end
        return result;
    endfunction

    // Gregorian leap-year rule on a plain year number.
    function automatic logic is_leap_year(input int unsigned year);
        return ((year % 4 == 0) && (year % 100 != 0)) || (year % 400 == 0);
    endfunction

endpackage

// File: rtl/utc_to_unix64_days_in_month.sv
// Combinational month length lookup with February leap correction.
module days_in_month
    import utc_to_unix64_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap,
    output logic [4:0] dim
);

    // Table lookup, then stretch February to 29 days in leap years.
    always_comb begin
        dim = dim_base(month);
        if (leap && (month == 4'd2)) begin
            dim = 5'd29;
        end
    end

endmodule

// File: rtl/utc_to_unix64.sv
// Iterative broken-down UTC to 64-bit Unix seconds converter.
// Walks one year per cycle, then one month per cycle, accumulating days,
// and finishes with a single shift-add multiply/accumulate step.
module utc_to_unix64 #(
    parameter int EPOCH_YEAR = utc_to_unix64_pkg::EPOCH_YEAR,
    parameter int YEAR_MAX   = utc_to_unix64_pkg::YEAR_MAX
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [13:0] year,
    input  logic [3:0]  month,
    input  logic [4:0]  day,
    input  logic [4:0]  hour,
    input  logic [5:0]  minute,
    input  logic [5:0]  second,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] unix_time
);
    import utc_to_unix64_pkg::*;

    // Year-phase counters start at the epoch so leap detection needs no divider.
    localparam logic [1:0] C4_INIT   = 2'(EPOCH_YEAR % 4);
    localparam logic [6:0] C100_INIT = 7'(EPOCH_YEAR % 100);
    localparam logic [8:0] C400_INIT = 9'(EPOCH_YEAR % 400);

    state_t              state_reg, state_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic [63:0]         unix_time_reg, unix_time_next;
    logic [13:0]         year_reg, year_next;
    logic [3:0]          month_reg, month_next;
    logic [4:0]          day_reg, day_next;
    logic [4:0]          hour_reg, hour_next;
    logic [5:0]          minute_reg, minute_next;
    logic [5:0]          second_reg, second_next;
    logic [13:0]         yr_reg, yr_next;
    logic [3:0]          mo_reg, mo_next;
    logic [DAYS_W-1:0]   days_reg, days_next;
    logic [1:0]          c4_reg, c4_next;
    logic [6:0]          c100_reg, c100_next;
    logic [8:0]          c400_reg, c400_next;

    logic                leap;
    logic                range_ok;
    logic [4:0]          dim;
    logic [DAYS_W-1:0]   days_total;
    logic [63:0]         days_wide;
    logic [63:0]         hour_wide;
    logic [63:0]         minute_wide;
    logic [63:0]         secs_total;

    assign leap = (c4_reg == 2'd0) && ((c100_reg != 7'd0) || (c400_reg == 9'd0));

    assign range_ok = (year_reg >= 14'(EPOCH_YEAR)) && (year_reg <= 14'(YEAR_MAX)) &&
                      (month_reg >= 4'd1) && (month_reg <= 4'd12) &&
                      (day_reg != 5'd0) && (hour_reg <= 5'd23) &&
                      (minute_reg <= 6'd59) && (second_reg <= 6'd59);

    days_in_month u_dim (
        .month (mo_reg),
        .leap  (leap),
        .dim   (dim)
    );

    // Final seconds: 86400 = 2^16+2^14+2^12+2^8+2^7, 3600 = 2^11+2^10+2^9+2^4, 60 = 2^6-2^2.
    always_comb begin
        days_total  = days_reg + DAYS_W'(day_reg) - DAYS_W'(1);
        days_wide   = 64'(days_total);
        hour_wide   = 64'(hour_reg);
        minute_wide = 64'(minute_reg);
        secs_total  = (days_wide << 16) + (days_wide << 14) + (days_wide << 12) +
                      (days_wide << 8) + (days_wide << 7) +
                      (hour_wide << 11) + (hour_wide << 10) + (hour_wide << 9) + (hour_wide << 4) +
                      (minute_wide << 6) - (minute_wide << 2) +
                      64'(second_reg);
    end

    // Next-state and datapath updates; done/err default low so they pulse.
    always_comb begin
        state_next     = state_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        unix_time_next = unix_time_reg;
        year_next      = year_reg;
        month_next     = month_reg;
        day_next       = day_reg;
        hour_next      = hour_reg;
        minute_next    = minute_reg;
        second_next    = second_reg;
        yr_next        = yr_reg;
        mo_next        = mo_reg;
        days_next      = days_reg;
        c4_next        = c4_reg;
        c100_next      = c100_reg;
        c400_next      = c400_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    year_next   = year;
                    month_next  = month;
                    day_next    = day;
                    hour_next   = hour;
                    minute_next = minute;
                    second_next = second;
                    busy_next   = 1'b1;
                    state_next  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!range_ok) begin
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    days_next  = '0;
                    yr_next    = 14'(EPOCH_YEAR);
                    c4_next    = C4_INIT;
                    c100_next  = C100_INIT;
                    c400_next  = C400_INIT;
                    state_next = ST_YEARS;
                end
            end
            ST_YEARS: begin
                if (yr_reg == year_reg) begin
                    mo_next    = 4'd1;
                    state_next = ST_MONTHS;
                end else begin
                    days_next = days_reg + (leap ? DAYS_W'(366) : DAYS_W'(365));
                    yr_next   = yr_reg + 14'd1;
                    c4_next   = c4_reg + 2'd1;
                    c100_next = (c100_reg == 7'd99)  ? 7'd0 : c100_reg + 7'd1;
                    c400_next = (c400_reg == 9'd399) ? 9'd0 : c400_reg + 9'd1;
                end
            end
            ST_MONTHS: begin
                if (mo_reg == month_reg) begin
                    if (day_reg > dim) begin
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                        busy_next  = 1'b0;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_CALC;
                    end
                end else begin
                    days_next = days_reg + DAYS_W'(dim);
                    mo_next   = mo_reg + 4'd1;
                end
            end
            ST_CALC: begin
                days_next      = days_total;
                unix_time_next = secs_total;
                done_next      = 1'b1;
                busy_next      = 1'b0;
                state_next     = ST_IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            unix_time_reg <= '0;
            year_reg      <= '0;
            month_reg     <= '0;
            day_reg       <= '0;
            hour_reg      <= '0;
            minute_reg    <= '0;
            second_reg    <= '0;
            yr_reg        <= '0;
            mo_reg        <= '0;
            days_reg      <= '0;
            c4_reg        <= '0;
            c100_reg      <= '0;
            c400_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            unix_time_reg <= unix_time_next;
            year_reg      <= year_next;
            month_reg     <= month_next;
            day_reg       <= day_next;
            hour_reg      <= hour_next;
            minute_reg    <= minute_next;
            second_reg    <= second_next;
            yr_reg        <= yr_next;
            mo_reg        <= mo_next;
            days_reg      <= days_next;
            c4_reg        <= c4_next;
            c100_reg      <= c100_next;
            c400_reg      <= c400_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign unix_time = unix_time_reg;

endmodule

// File: tb/tb_utc_to_unix64.sv
// Randomized and directed bench for utc_to_unix64 with a calendar-level model.
module tb_utc_to_unix64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] year = '0;
    logic [3:0]  month = '0;
    logic [4:0]  day = '0;
    logic [4:0]  hour = '0;
    logic [5:0]  minute = '0;
    logic [5:0]  second = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] unix_time;

    int tests = 0;
    int fails = 0;

    utc_to_unix64 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .year      (year),
        .month     (month),
        .day       (day),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .unix_time (unix_time)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    // Calendar model: result, error flag and cycles from accept edge to done.
    function automatic void model_op(input int y, input int mo, input int d, input int h,
                                     input int mi, input int s, output bit e, output int lat,
                                     output longint unsigned ut);
        int mdays[13];
        int days;
        mdays = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        e = 1'b0;
        lat = 1;
        ut = 0;
        if (y < 1970 || y > 9999 || mo < 1 || mo > 12 || d < 1 || d > 31 ||
            h > 23 || mi > 59 || s > 59) begin
            e = 1'b1;
            return;
        end
        days = 0;
        for (int yy = 1970; yy < y; yy++) days += is_leap(yy) ? 366 : 365;
        if (is_leap(y)) mdays[2] = 29;
        for (int m = 1; m < mo; m++) days += mdays[m];
        if (d > mdays[mo]) begin
            e = 1'b1;
            lat = (y - 1970) + (mo - 1) + 3;
            return;
        end
        days += d - 1;
        ut = longint'(days) * 86400 + longint'(h) * 3600 + longint'(mi) * 60 + longint'(s);
        lat = (y - 1970) + (mo - 1) + 4;
    endfunction

    // Model of what the DUT has accepted, advanced at every clock edge.
    int               cyc = 0;
    bit               pend = 1'b0;
    int               e0_cyc = 0;
    int               done_cyc = 0;
    bit               pend_err = 1'b0;
    longint unsigned  pend_ut = 0;
    longint unsigned  model_ut = 0;

    always @(posedge clk) begin
        bit e;
        int lat;
        longint unsigned ut;
        cyc++;
        if (!reset_n) begin
            pend = 1'b0;
            model_ut = 0;
        end else begin
            if (pend && cyc == done_cyc && !pend_err) model_ut = pend_ut;
            if (start && !(pend && cyc <= done_cyc)) begin
                model_op(int'(year), int'(month), int'(day), int'(hour), int'(minute),
                         int'(second), e, lat, ut);
                pend = 1'b1;
                pend_err = e;
                pend_ut = ut;
                e0_cyc = cyc;
                done_cyc = cyc + lat;
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        bit ed;
        bit eb;
        ed = pend && (cyc == done_cyc);
        eb = pend && (cyc >= e0_cyc) && (cyc < done_cyc);
        check("done", 64'(done), 64'(ed));
        check("busy", 64'(busy), 64'(eb));
        check("err", 64'(err), 64'(ed && pend_err));
        check("unix_time", unix_time, model_ut);
    end

    task automatic scramble();
        year   = 14'($urandom);
        month  = 4'($urandom);
        day    = 5'($urandom);
        hour   = 5'($urandom);
        minute = 6'($urandom);
        second = 6'($urandom);
    endtask

    task automatic launch(input int y, input int mo, input int d, input int h,
                          input int mi, input int s);
        @(negedge clk);
        year = 14'(y); month = 4'(mo); day = 5'(d);
        hour = 5'(h); minute = 6'(mi); second = 6'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
    endtask

    // Counts cycles after the accept edge until done is seen, bounded.
    task automatic wait_done(input int budget, output int k);
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic directed(input string name, input int y, input int mo, input int d,
                            input int h, input int mi, input int s, input bit exp_err,
                            input longint unsigned exp_ut, input int exp_lat);
        int k;
        launch(y, mo, d, h, mi, s);
        wait_done(9000, k);
        check({name, "_latency"}, 64'(k), 64'(exp_lat));
        check({name, "_err"}, 64'(err), 64'(exp_err));
        check({name, "_unix"}, unix_time, exp_ut);
    endtask

    task automatic rand_fields(output int y, output int mo, output int d, output int h,
                               output int mi, output int s);
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0)      y = int'($urandom_range(0, 1969));
        else if (r == 1) y = int'($urandom_range(10000, 16383));
        else             y = int'($urandom_range(1968, 2110));
        mo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 12));
        d  = int'($urandom_range(0, 31));
        h  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 23));
        mi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 59));
        s  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 59));
    endtask

    initial begin
        int k;
        int extra;
        int y, mo, d, h, mi, s;

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_unix", unix_time, 64'd0);
        reset_n = 1'b1;

        directed("epoch", 1970, 1, 1, 0, 0, 0, 1'b0, 64'd0, 4);
        directed("y2000", 2000, 1, 1, 0, 0, 0, 1'b0, 64'd946684800, 34);
        directed("y2024", 2024, 8, 27, 9, 53, 19, 1'b0, 64'd1724752399, 65);
        directed("feb29_2000", 2000, 2, 29, 12, 0, 0, 1'b0, 64'd951825600, 35);
        directed("feb29_2023", 2023, 2, 29, 0, 0, 0, 1'b1, 64'd951825600, 57);
        directed("feb29_2100", 2100, 2, 29, 0, 0, 0, 1'b1, 64'd951825600, 134);
        directed("y1969", 1969, 12, 31, 0, 0, 0, 1'b1, 64'd951825600, 1);
        directed("month13", 2000, 13, 1, 0, 0, 0, 1'b1, 64'd951825600, 1);
        directed("y10000", 10000, 1, 1, 0, 0, 0, 1'b1, 64'd951825600, 1);
        directed("ymax", 9999, 12, 31, 23, 59, 59, 1'b0, 64'd253402300799, 8044);

        // Extra start while busy must be ignored.
        launch(2000, 1, 1, 0, 0, 0);
        repeat (5) @(negedge clk);
        year = 14'd1970; month = 4'd1; day = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, k);
        check("busy_start_unix", unix_time, 64'd946684800);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("busy_start_single_done", 64'(extra), 64'd0);

        // Reset in the middle of the year walk, then a clean conversion.
        launch(2024, 8, 27, 9, 53, 19);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_err", 64'(err), 64'd0);
        check("midreset_unix", unix_time, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        directed("after_reset", 2024, 8, 27, 9, 53, 19, 1'b0, 64'd1724752399, 65);

        // Random single transactions.
        for (int i = 0; i < 40; i++) begin
            rand_fields(y, mo, d, h, mi, s);
            launch(y, mo, d, h, mi, s);
            wait_done(9000, k);
            if (k >= 9000) check("rand_timeout", 64'(k), 64'd0);
            $display("[TB] op %0d: %0d-%0d-%0d %0d:%0d:%0d err=%0d unix=%0d", i, y, mo, d,
                     h, mi, s, err, unix_time);
        end

        // Start held high most of the time: exercises back-to-back and done-edge starts.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            year = 14'($urandom_range(1966, 1975));
            month = 4'($urandom_range(1, 12));
            day = 5'($urandom_range(1, 31));
            hour = 5'($urandom_range(0, 23));
            minute = 6'($urandom_range(0, 59));
            second = 6'($urandom_range(0, 59));
        end
        start = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("final_idle", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
